// File: rtl/alu_ctrl_stage.sv
// ID/EX boundary for the ALU control path: decodes the ID instruction into ALU control,
// operand select and immediate, with stall hold, flush-to-bubble and illegal tracking.
module alu_ctrl_stage #(
  parameter logic [3:0]  ILLEGAL_F = 4'b0010,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr_d,
  input  logic             valid_d,
  input  logic             stall_e,
  input  logic             flush_e,
  output logic [3:0]       alu_f_e,
  output logic             alusrc_e,
  output logic [31:0]      imm_e,
  output logic             valid_e,
  output logic             illegal_e,
  output logic             illegal_sticky,
  output logic [CNT_W-1:0] op_count_e
);

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [3:0]  dec_f;
  logic        dec_src;
  logic        dec_sext;
  logic        dec_legal;
  logic        dec_nop;
  logic [31:0] dec_imm;

  assign op    = instr_d[31:26];
  assign funct = instr_d[5:0];

  always_comb begin
    dec_f     = ILLEGAL_F;
    dec_src   = 1'b0;
    dec_sext  = 1'b1;
    dec_legal = 1'b0;
    case (op)
      6'b000000: begin
        dec_legal = 1'b1;
        case (funct)
          6'b100000: dec_f = 4'b0010;
          6'b100010: dec_f = 4'b1010;
          6'b100100: dec_f = 4'b0000;
          6'b100101: dec_f = 4'b0001;
          6'b101010: dec_f = 4'b1011;
          default:   dec_legal = 1'b0;
        endcase
      end
      6'b100011, 6'b101011, 6'b001000: begin
        dec_f     = 4'b0010;
        dec_src   = 1'b1;
        dec_legal = 1'b1;
      end
      6'b000100: begin
        dec_f     = 4'b1010;
        dec_legal = 1'b1;
      end
      6'b001100: begin
        dec_f     = 4'b0000;
        dec_src   = 1'b1;
        dec_sext  = 1'b0;
        dec_legal = 1'b1;
      end
      6'b001101: begin
        dec_f     = 4'b0001;
        dec_src   = 1'b1;
        dec_sext  = 1'b0;
        dec_legal = 1'b1;
      end
      6'b001010: begin
        dec_f     = 4'b1011;
        dec_src   = 1'b1;
        dec_legal = 1'b1;
      end
      // Jump is legal but never uses the ALU result.
      6'b000010: dec_legal = 1'b1;
      default: ;
    endcase
  end

  assign dec_nop = (instr_d == 32'h0);
  assign dec_imm = dec_sext ? {{16{instr_d[15]}}, instr_d[15:0]} : {16'h0, instr_d[15:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_f_e        <= ILLEGAL_F;
      alusrc_e       <= 1'b0;
      imm_e          <= 32'h0;
      valid_e        <= 1'b0;
      illegal_e      <= 1'b0;
      illegal_sticky <= 1'b0;
      op_count_e     <= '0;
    end else if (flush_e) begin
      alu_f_e   <= ILLEGAL_F;
      alusrc_e  <= 1'b0;
      imm_e     <= 32'h0;
      valid_e   <= 1'b0;
      illegal_e <= 1'b0;
    end else if (!stall_e) begin
      if (valid_d && !dec_nop && dec_legal) begin
        alu_f_e   <= dec_f;
        alusrc_e  <= dec_src;
        imm_e     <= dec_imm;
        valid_e   <= 1'b1;
        illegal_e <= 1'b0;
        if (op_count_e != {CNT_W{1'b1}}) begin
          op_count_e <= op_count_e + CNT_W'(1);
        end
      end else if (valid_d && !dec_nop) begin
        alu_f_e        <= ILLEGAL_F;
        alusrc_e       <= 1'b0;
        imm_e          <= 32'h0;
        valid_e        <= 1'b0;
        illegal_e      <= 1'b1;
        illegal_sticky <= 1'b1;
      end else begin
        alu_f_e   <= ILLEGAL_F;
        alusrc_e  <= 1'b0;
        imm_e     <= 32'h0;
        valid_e   <= 1'b0;
        illegal_e <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Bench for alu_ctrl_stage: directed scenarios then random stimulus against a table-driven
// model of the instruction set and EX slot.
module tb_alu_ctrl_stage;

  localparam logic [3:0] ILL_F = 4'b0010;
  localparam int CMAX = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr_d = 32'h0;
  logic        valid_d = 1'b0;
  logic        stall_e = 1'b0;
  logic        flush_e = 1'b0;
  logic [3:0]  alu_f_e;
  logic        alusrc_e;
  logic [31:0] imm_e;
  logic        valid_e;
  logic        illegal_e;
  logic        illegal_sticky;
  logic [3:0]  op_count_e;

  alu_ctrl_stage #(.ILLEGAL_F(ILL_F), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .instr_d(instr_d), .valid_d(valid_d), .stall_e(stall_e),
    .flush_e(flush_e), .alu_f_e(alu_f_e), .alusrc_e(alusrc_e), .imm_e(imm_e),
    .valid_e(valid_e), .illegal_e(illegal_e), .illegal_sticky(illegal_sticky),
    .op_count_e(op_count_e)
  );

  always #5 clk = ~clk;

  // ext: 0 = immediate unused, 1 = sign-extend, 2 = zero-extend
  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       use_fn;
    logic [3:0] f;
    logic       src;
    int         ext;
  } row_t;
  row_t tbl[$];

  int n_checks = 0;
  int n_pass = 0;

  // Model of the EX slot
  logic [3:0]  m_f;
  logic        m_src;
  logic [31:0] m_imm;
  logic        m_imm_ok;
  logic        m_valid;
  logic        m_ill;
  logic        m_sticky;
  int          m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_bubble();
    m_f = ILL_F; m_src = 1'b0; m_imm = 32'h0; m_imm_ok = 1'b1; m_valid = 1'b0; m_ill = 1'b0;
  endtask

  task automatic model_reset();
    model_bubble();
    m_sticky = 1'b0;
    m_cnt = 0;
  endtask

  task automatic model_update(input logic [31:0] ins, input logic vd, input logic st,
                              input logic fl);
    bit found = 0;
    row_t r;
    if (fl) begin
      model_bubble();
      return;
    end
    if (st) return;
    if (!vd || ins == 32'h0) begin
      model_bubble();
      return;
    end
    foreach (tbl[i]) begin
      if (!found && tbl[i].op == ins[31:26] && (!tbl[i].use_fn || tbl[i].fn == ins[5:0])) begin
        found = 1;
        r = tbl[i];
      end
    end
    if (found) begin
      m_f = r.f;
      m_src = r.src;
      m_valid = 1'b1;
      m_ill = 1'b0;
      m_imm_ok = (r.ext != 0);
      m_imm = (r.ext == 2) ? {16'h0, ins[15:0]} : {{16{ins[15]}}, ins[15:0]};
      if (m_cnt < CMAX) m_cnt++;
    end else begin
      m_f = ILL_F; m_src = 1'b0; m_valid = 1'b0; m_ill = 1'b1; m_sticky = 1'b1;
      m_imm_ok = 1'b0;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".f"}, 32'(alu_f_e), 32'(m_f));
    check({tag, ".src"}, 32'(alusrc_e), 32'(m_src));
    check({tag, ".valid"}, 32'(valid_e), 32'(m_valid));
    check({tag, ".ill"}, 32'(illegal_e), 32'(m_ill));
    check({tag, ".sticky"}, 32'(illegal_sticky), 32'(m_sticky));
    check({tag, ".cnt"}, 32'(op_count_e), 32'(m_cnt));
    if (m_imm_ok) check({tag, ".imm"}, imm_e, m_imm);
  endtask

  task automatic step(input string tag, input logic [31:0] ins, input logic vd, input logic st,
                      input logic fl);
    instr_d = ins; valid_d = vd; stall_e = st; flush_e = fl;
    @(posedge clk);
    #1;
    model_update(ins, vd, st, fl);
    compare_all(tag);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #1;
    model_reset();
    compare_all("reset");
    #1;
    reset = 1'b0;
  endtask

  function automatic logic [31:0] rtype(input logic [5:0] fn);
    return {6'b0, 5'd1, 5'd2, 5'd3, 5'd0, fn};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0] ops[12];
    logic [5:0] fns[7];
    logic [31:0] w;
    ops = '{6'h00, 6'h00, 6'h00, 6'h23, 6'h2B, 6'h08, 6'h04, 6'h0C, 6'h0D, 6'h0A, 6'h02, 6'h3F};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h21, 6'h00};
    if ($urandom_range(0, 15) == 0) return 32'h0;
    w = $urandom;
    if ($urandom_range(0, 7) == 0) return w;
    w[31:26] = ops[$urandom_range(0, 11)];
    if (w[31:26] == 6'h00) w[5:0] = fns[$urandom_range(0, 6)];
    return w;
  endfunction

  initial begin
    tbl.push_back('{6'h00, 6'h20, 1'b1, 4'b0010, 1'b0, 0});
    tbl.push_back('{6'h00, 6'h22, 1'b1, 4'b1010, 1'b0, 0});
    tbl.push_back('{6'h00, 6'h24, 1'b1, 4'b0000, 1'b0, 0});
    tbl.push_back('{6'h00, 6'h25, 1'b1, 4'b0001, 1'b0, 0});
    tbl.push_back('{6'h00, 6'h2A, 1'b1, 4'b1011, 1'b0, 0});
    tbl.push_back('{6'h23, 6'h00, 1'b0, 4'b0010, 1'b1, 1});
    tbl.push_back('{6'h2B, 6'h00, 1'b0, 4'b0010, 1'b1, 1});
    tbl.push_back('{6'h08, 6'h00, 1'b0, 4'b0010, 1'b1, 1});
    tbl.push_back('{6'h04, 6'h00, 1'b0, 4'b1010, 1'b0, 1});
    tbl.push_back('{6'h0C, 6'h00, 1'b0, 4'b0000, 1'b1, 2});
    tbl.push_back('{6'h0D, 6'h00, 1'b0, 4'b0001, 1'b1, 2});
    tbl.push_back('{6'h0A, 6'h00, 1'b0, 4'b1011, 1'b1, 1});
    tbl.push_back('{6'h02, 6'h00, 1'b0, ILL_F,   1'b0, 0});

    model_reset();
    #12;
    compare_all("init");
    reset = 1'b0;

    // Async reset mid-cycle with a live slot
    step("pre_rst", rtype(6'h22), 1'b1, 1'b0, 1'b0);
    #3;
    apply_reset();
    check("rst_valid_lit", 32'(valid_e), 32'd0);
    check("rst_f_lit", 32'(alu_f_e), 32'(ILL_F));

    // Decode sweep
    step("add", rtype(6'h20), 1'b1, 1'b0, 1'b0);
    check("add_f_lit", 32'(alu_f_e), 32'h2);
    step("sub", rtype(6'h22), 1'b1, 1'b0, 1'b0);
    step("and", rtype(6'h24), 1'b1, 1'b0, 1'b0);
    step("or", rtype(6'h25), 1'b1, 1'b0, 1'b0);
    step("slt", rtype(6'h2A), 1'b1, 1'b0, 1'b0);
    check("slt_f_lit", 32'(alu_f_e), 32'hB);
    step("lw", 32'h8C22FFFC, 1'b1, 1'b0, 1'b0);
    check("lw_imm_lit", imm_e, 32'hFFFFFFFC);
    check("lw_src_lit", 32'(alusrc_e), 32'd1);
    step("andi", 32'h3042FFFF, 1'b1, 1'b0, 1'b0);
    check("andi_imm_lit", imm_e, 32'h0000FFFF);
    step("ori", 32'h34428001, 1'b1, 1'b0, 1'b0);
    step("slti", 32'h28428001, 1'b1, 1'b0, 1'b0);
    step("beq", 32'h1022FFF0, 1'b1, 1'b0, 1'b0);
    step("j", 32'h08001234, 1'b1, 1'b0, 1'b0);

    // Stall hold then stall+flush
    step("ld_sub", rtype(6'h22), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("stall", 32'h3042FFFF, 1'b1, 1'b1, 1'b0);
    check("stall_f_lit", 32'(alu_f_e), 32'hA);
    step("stall_flush", rtype(6'h20), 1'b1, 1'b1, 1'b1);
    step("flush", rtype(6'h20), 1'b1, 1'b0, 1'b1);

    // Illegal and nop
    step("illegal", 32'hFC000000, 1'b1, 1'b0, 1'b0);
    check("ill_lit", 32'(illegal_e), 32'd1);
    step("after_ill", rtype(6'h20), 1'b1, 1'b0, 1'b0);
    check("sticky_lit", 32'(illegal_sticky), 32'd1);
    step("bad_funct", rtype(6'h21), 1'b1, 1'b0, 1'b0);
    step("nop", 32'h0, 1'b1, 1'b0, 1'b0);
    step("invalid", rtype(6'h20), 1'b0, 1'b0, 1'b0);

    // Counter saturation with interleaved stalls and bubbles
    @(negedge clk);
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      step("cnt_ld", 32'h20010005 + 32'(i), 1'b1, 1'b0, 1'b0);
      if (i % 3 == 0) step("cnt_stall", rtype(6'h20), 1'b1, 1'b1, 1'b0);
      if (i % 4 == 0) step("cnt_bub", rtype(6'h20), 1'b0, 1'b0, 1'b0);
    end
    check("cnt_sat_lit", 32'(op_count_e), 32'd15);

    // Random phase
    @(negedge clk);
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      step("rand", rand_instr(), 1'($urandom_range(0, 7) != 0),
           1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 9) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
